// File: rtl/sha3_state_emit.sv
// sha3_state_emit
//   Captures a full 5x5 Keccak state (five 5-lane row buses) in one accepted
//   cycle and replays its first LANES_OUT lanes as a 64-bit valid/ready stream,
//   one lane per accepted beat, in linear lane order (k -> row k/5, col k%5).
//
// Ports
//   clk                     clock, rising edge
//   rst                     synchronous reset, active low
//   isa..ise [4:0][63:0]    state rows a..e, sampled only on accept
//   igood                   upstream state valid
//   iready                  block can take a state this cycle (combinational
//                           from dready; forced 0 while rst is low)
//   odata [63:0]            current lane (registered)
//   ovalid                  odata valid (registered)
//   olast                   odata is lane LANES_OUT-1 (registered)
//   dready                  downstream takes the beat

// One buffered lane: loads on capture, cleared on reset.
module sha3_emit_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [63:0] din,
  output logic [63:0] q
);
  always_ff @(posedge clk) begin
    if (!rst)    q <= '0;
    else if (ld) q <= din;
  end
endmodule

module sha3_state_emit #(
  parameter int LANES_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  input  logic             igood,
  output logic             iready,
  output logic [63:0]      odata,
  output logic             ovalid,
  output logic             olast,
  input  logic             dready
);

  if (LANES_OUT < 1 || LANES_OUT > 25) begin : g_bad_param
    $error("sha3_state_emit: LANES_OUT must be 1..25");
  end

  localparam logic [4:0] LAST = 5'(LANES_OUT - 1);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t           state;
  logic [4:0]       idx;
  logic [4:0]       idx_nxt;
  logic             acc;
  logic             hs;
  logic [24:0][63:0] lanes_in;
  // 32 entries so the 5-bit index selects directly; entries at or above
  // LANES_OUT are constant zero and never stored.
  logic [31:0][63:0] lbuf;

  // Row a lands in lanes 0..4, row e in 20..24.
  assign lanes_in = {ise, isd, isc, isb, isa};

  assign iready  = rst && ((state == S_IDLE) || (state == S_EMIT && olast && dready));
  assign acc     = igood && iready;
  assign hs      = ovalid && dready;
  assign idx_nxt = idx + 5'd1;

  for (genvar k = 0; k < 32; k++) begin : g_lane
    if (k < LANES_OUT) begin : g_store
      sha3_emit_lane u_lane (
        .clk (clk),
        .rst (rst),
        .ld  (acc),
        .din (lanes_in[k]),
        .q   (lbuf[k])
      );
    end else begin : g_zero
      assign lbuf[k] = '0;
    end
  end

  // odata is loaded one step ahead from the buffer (or straight from the
  // input on capture) so it stays a pure register output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      ovalid <= 1'b0;
      olast  <= 1'b0;
      odata  <= '0;
    end else if (acc) begin
      // Covers both IDLE capture and reload on the final beat.
      state  <= S_EMIT;
      idx    <= '0;
      ovalid <= 1'b1;
      olast  <= (LANES_OUT == 1);
      odata  <= lanes_in[0];
    end else if (hs) begin
      if (!olast) begin
        idx   <= idx_nxt;
        odata <= lbuf[idx_nxt];
        olast <= (idx_nxt == LAST);
      end else begin
        state  <= S_IDLE;
        idx    <= '0;
        ovalid <= 1'b0;
        olast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha3_state_emit.sv
// Bench for sha3_state_emit: three instances (LANES_OUT = 4, 25, 1) share one
// stimulus stream. Each has a reference model holding a snapshot of the lanes
// and a count of beats still owed; every cycle the outputs and iready are
// compared against it.
module tb_sha3_state_emit;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0][63:0] isa, isb, isc, isd, ise;
  logic             igood, dready;
  logic             ir [3];
  logic             ov [3];
  logic             ol [3];
  logic [63:0]      od [3];

  int          n_chk = 0;
  int          n_err = 0;
  int          nl [3] = '{4, 25, 1};
  logic [63:0] ml [3][25];
  int          mpos [3];
  int          mrem [3];
  logic [63:0] lv [25];
  bit          armed = 1'b0;
  bit          last_rst = 1'b0;

  always #5 clk = ~clk;

  sha3_state_emit #(.LANES_OUT(4)) u_d4 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .igood(igood), .iready(ir[0]), .odata(od[0]), .ovalid(ov[0]), .olast(ol[0]),
    .dready(dready));

  sha3_state_emit #(.LANES_OUT(25)) u_d25 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .igood(igood), .iready(ir[1]), .odata(od[1]), .ovalid(ov[1]), .olast(ol[1]),
    .dready(dready));

  sha3_state_emit #(.LANES_OUT(1)) u_d1 (
    .clk(clk), .rst(rst), .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .igood(igood), .iready(ir[2]), .odata(od[2]), .ovalid(ov[2]), .olast(ol[2]),
    .dready(dready));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present lv[] on the row buses: lane k -> row k/5, column k%5.
  task automatic set_rows();
    for (int k = 0; k < 25; k++) begin
      case (k / 5)
        0: isa[k % 5] = lv[k];
        1: isb[k % 5] = lv[k];
        2: isc[k % 5] = lv[k];
        3: isd[k % 5] = lv[k];
        default: ise[k % 5] = lv[k];
      endcase
    end
  endtask

  // Drive one cycle of inputs, check every instance against its model,
  // advance the models across the coming edge, then move to the next cycle.
  task automatic step(input logic r, input logic g, input logic d);
    logic exp_ir;
    rst = r; igood = g; dready = d;
    set_rows();
    #1;
    for (int m = 0; m < 3; m++) begin
      exp_ir = r && (mrem[m] == 0 || (mrem[m] == 1 && d));
      if (armed || !r) chk($sformatf("d%0d_iready", nl[m]), 64'(ir[m]), 64'(exp_ir));
      if (armed) begin
        chk($sformatf("d%0d_ovalid", nl[m]), 64'(ov[m]), 64'(mrem[m] != 0));
        chk($sformatf("d%0d_olast", nl[m]), 64'(ol[m]), 64'(mrem[m] == 1));
        if (mrem[m] != 0)
          chk($sformatf("d%0d_odata", nl[m]), od[m], ml[m][mpos[m]]);
        else if (last_rst)
          chk($sformatf("d%0d_odata_rst", nl[m]), od[m], 64'h0);
      end
      if (!r) begin
        mrem[m] = 0;
        mpos[m] = 0;
      end else begin
        if (mrem[m] != 0 && d) begin
          mpos[m]++;
          mrem[m]--;
        end
        if (g && exp_ir) begin
          for (int k = 0; k < nl[m]; k++) ml[m][k] = lv[k];
          mpos[m] = 0;
          mrem[m] = nl[m];
        end
      end
    end
    if (!r) armed = 1'b1;
    last_rst = !r;
    @(negedge clk);
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin mpos[m] = 0; mrem[m] = 0; end
    for (int k = 0; k < 25; k++) lv[k] = 64'(k) * 64'h0101;
    rst = 1'b0; igood = 1'b0; dready = 1'b0;
    set_rows();
    @(negedge clk);

    // Reset held 3 cycles with igood/dready high: no capture, no beats.
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);

    // Full state: lane k = k*0x0101; beat 7 of the 25-lane instance is isb[2].
    step(1'b1, 1'b1, 1'b1);
    repeat (7) step(1'b1, 1'b0, 1'b1);
    chk("d25_beat7", od[1], 64'h0707);
    repeat (17) step(1'b1, 1'b0, 1'b1);
    chk("d25_lastbeat", od[1], 64'h1818);
    chk("d25_lastflag", 64'(ol[1]), 64'h1);
    repeat (3) step(1'b1, 1'b0, 1'b1);

    // Basic + backpressure, then back-to-back with igood held high.
    for (int k = 0; k < 25; k++) lv[k] = 64'h1000 + 64'(k);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 25; k++) lv[k] = 64'h2000 + 64'(k);
    repeat (8) step(1'b1, 1'b1, 1'b1);

    // Busy pulses, then reset mid-stream.
    for (int k = 0; k < 25; k++) lv[k] = 64'h1000 + 64'(k);
    repeat (3) step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 25; k++) lv[k] = 64'hDEAD + 64'(k);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b1);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      for (int k = 0; k < 25; k++) lv[k] = {$urandom(), $urandom()};
      step(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 40),
           ($urandom_range(0, 99) < 70));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sha3_state_emit.md
# sha3_state_emit

Serializes a full 5x5 Keccak state, presented as five 5-lane row buses with a single-cycle strobe, into a stream of 64-bit lanes with a valid/ready handshake. It sits at the output of the permutation core and is the counterpart of the parallel state-capture path. It feeds digest/squeeze logic or a narrow host interface one lane per accepted beat. It holds a private copy of the state, so the core is free to continue once a state is accepted.

## Interface
- LANES_OUT, default 4: number of lanes emitted per state, linear order. Legal range is 1..25; any other value is an elaboration `$error`. Typical values are 4 (256-bit digest) and 17 (SHA3-256 rate).
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- isa, isb, isc, isd, ise  input  64 x [5] each  state rows. Linear lane index k maps to row k/5 (a..e) and column k%5. Example: lane 7 = isb[2].
- igood  input  1  upstream state valid; data is sampled only on accept.
- iready  output  1  this block can accept a state this cycle.
- odata  output  64  current lane.
- ovalid  output  1  odata is valid.
- olast  output  1  odata is lane LANES_OUT-1 of the current state.
- dready  input  1  downstream accepts the beat.

## Operation
- Storage: LANES_OUT x 64-bit buffer. Lanes at or above LANES_OUT are never stored.
- Accept: an input accept occurs when igood && iready.
  - On accept, copy lanes 0..LANES_OUT-1 into the buffer.
  - Set idx=0 and enter EMIT.
- States:
  - IDLE: ovalid=0, iready=1.
  - EMIT: ovalid=1, odata=buf[idx], olast=(idx==LANES_OUT-1).
- Transitions:
  - Beat handshake is ovalid && dready.
  - On a handshake with !olast, idx increments.
  - On a handshake with olast: if igood in the same cycle, reload the buffer, set idx=0 and stay in EMIT. Otherwise go to IDLE.
- iready definition:
  - iready = (state==IDLE) || (state==EMIT && olast && dready).
  - It is combinational from dready; this is the only combinational input-to-output path.
  - iready is forced 0 while rst is low.
- Busy input: igood while iready=0 is ignored. No capture, no error, no state change.
- Counter: idx is 5 bits wide and wraps to 0 only through the reload/IDLE path. It never exceeds LANES_OUT-1.
- Output stability: while ovalid && !dready, odata and olast hold stable. ovalid never drops without a handshake, except on reset.

## Timing
- Reset (rst low at a clock edge): state=IDLE, idx=0, buffer cleared to 0, ovalid=0, olast=0, odata=64'h0. iready=0 while rst is low and 1 on the first cycle after release.
- Reset mid-EMIT: the stream is abandoned with no further beats. The next accepted state starts at lane 0.
- Latency: accept in cycle N gives lane 0 with ovalid=1 in cycle N+1.
- Throughput: with dready held at 1, one lane per cycle. Back-to-back states give LANES_OUT beats per state with zero bubbles.
- LANES_OUT=1: every beat has olast=1. With igood held high, iready=dready every cycle.
- All outputs except iready are registered.

## Test plan
- Reset:
  - Stimulus: hold rst low for 3 cycles while driving igood=1 and dready=1.
  - Required: ovalid=0, olast=0, odata=0 and iready=0 throughout; iready=1 in the cycle after release; no beat emitted.
- Basic, LANES_OUT=4:
  - Stimulus: lane k = 64'h1000+k; igood pulsed in cycle 10; dready=1.
  - Required: odata 0x1000, 0x1001, 0x1002, 0x1003 in cycles 11–14; olast only in cycle 14; ovalid=0 in cycle 15.
- Backpressure:
  - Stimulus: same as basic, but dready=0 in cycles 12–13.
  - Required: odata holds 0x1001 with ovalid=1 in cycles 12–13; 0x1003 with olast in cycle 16; no lane skipped or duplicated.
- Back-to-back:
  - Stimulus: igood held high; second state lane k = 64'h2000+k presented.
  - Required: 0x1003 (olast) in cycle 14; iready=1 in cycle 14; 0x2000 in cycle 15 with no bubble.
- Busy ignore plus mid-stream reset:
  - Stimulus: igood pulsed in cycle 12 with lanes 64'hDEAD+k.
  - Required: sequence still ends 0x1002, 0x1003. With rst low in cycle 12, ovalid=0 from cycle 13 and no residual beats after release.
- Full state, LANES_OUT=25:
  - Stimulus: lane k = k*64'h0101.
  - Required: 25 beats; beat 7 = isb[2] = 64'h0707; last beat = ise[4] = 64'h1818 with olast=1.
